// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: widths, state codes and
// the latency-to-counter helper used by the FSM.
package data_mem_responder_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_READ_WAIT  = 2'd1;
    localparam logic [1:0] ST_WRITE_WAIT = 2'd2;

    // The counter is loaded with LAT-1 so the completion edge is N+LAT.
    function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
        lat_to_cnt = CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// 256x16 storage: synchronous write port, combinational read port.
// Contents are deliberately not reset.
module mem_array_256x16
    import data_mem_responder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Write port: commit on the clock edge when enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load or store at a time, answers after a
// programmable latency and flags protocol violations in a sticky error bit.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1,
    parameter int DEPTH         = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              readReq,
    input  logic              writeReq,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memValueStore,
    output logic [DATA_W-1:0] memValueLoad,
    output logic              valueReady,
    output logic              writeDone,
    output logic              busy,
    output logic              reqError
);

    localparam logic [CNT_W-1:0] RD_CNT = lat_to_cnt(READ_LATENCY);
    localparam logic [CNT_W-1:0] WR_CNT = lat_to_cnt(WRITE_LATENCY);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_load;
    logic              r_value_ready;
    logic              r_write_done;
    logic              r_busy;
    logic              r_req_error;
    logic              r_read_q;
    logic              r_write_q;

    logic              w_mem_we;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rise_busy;

    // A request held since acceptance is fine; only a fresh rising edge while busy is an error.
    assign w_rise_busy = (r_state != ST_IDLE) &&
                         ((readReq && !r_read_q) || (writeReq && !r_write_q));
    assign w_mem_we    = (r_state == ST_WRITE_WAIT) && (r_cnt == 4'd0);

    mem_array_256x16 u_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_addr  (r_addr),
        .i_wdata (r_data),
        .o_rdata (w_rd_data)
    );

    // Request FSM, latency counter, response pulses and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_addr        <= 8'd0;
            r_data        <= 16'd0;
            r_load        <= 16'd0;
            r_value_ready <= 1'b0;
            r_write_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_req_error   <= 1'b0;
            r_read_q      <= 1'b0;
            r_write_q     <= 1'b0;
        end else begin
            r_read_q      <= readReq;
            r_write_q     <= writeReq;
            r_value_ready <= 1'b0;
            r_write_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (writeReq) begin
                        r_addr  <= memAddr;
                        r_data  <= memValueStore;
                        r_cnt   <= WR_CNT;
                        r_busy  <= 1'b1;
                        r_state <= ST_WRITE_WAIT;
                        if (readReq) begin
                            r_req_error <= 1'b1;
                        end
                    end else if (readReq) begin
                        r_addr  <= memAddr;
                        r_cnt   <= RD_CNT;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_load        <= w_rd_data;
                        r_value_ready <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_WRITE_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_write_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_rise_busy) begin
                r_req_error <= 1'b1;
            end
        end
    end

    assign memValueLoad = r_load;
    assign valueReady   = r_value_ready;
    assign writeDone    = r_write_done;
    assign busy         = r_busy;
    assign reqError     = r_req_error;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default latencies on one instance,
// WRITE_LATENCY=3 on a second for the reset-during-write case.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst1, rd1, wr1, vr1, wd1, busy1, err1;
    logic [7:0]  addr1;
    logic [15:0] wdata1, load1;
    logic        rst3, rd3, wr3, vr3, wd3, busy3, err3;
    logic [7:0]  addr3;
    logic [15:0] wdata3, load3;

    int n_vec = 0;
    int n_err = 0;
    int pulses;

    always #5 clk = ~clk;

    data_mem_responder #(.READ_LATENCY(2), .WRITE_LATENCY(1), .DEPTH(256)) dut1 (
        .clk(clk), .rst(rst1), .readReq(rd1), .writeReq(wr1), .memAddr(addr1),
        .memValueStore(wdata1), .memValueLoad(load1), .valueReady(vr1),
        .writeDone(wd1), .busy(busy1), .reqError(err1)
    );

    data_mem_responder #(.READ_LATENCY(2), .WRITE_LATENCY(3), .DEPTH(256)) dut3 (
        .clk(clk), .rst(rst3), .readReq(rd3), .writeReq(wr3), .memAddr(addr3),
        .memValueStore(wdata3), .memValueLoad(load3), .valueReady(vr3),
        .writeDone(wd3), .busy(busy3), .reqError(err3)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; addr1 = 8'h00; wdata1 = 16'h0000;
        rst3 = 1'b0; rd3 = 1'b0; wr3 = 1'b0; addr3 = 8'h00; wdata3 = 16'h0000;
        repeat (2) tick();
        check_eq("rst_load",  load1,       16'h0000);
        check_eq("rst_vr",    16'(vr1),    16'd0);
        check_eq("rst_wd",    16'(wd1),    16'd0);
        check_eq("rst_busy",  16'(busy1),  16'd0);
        check_eq("rst_err",   16'(err1),   16'd0);
        rst1 = 1'b1; rst3 = 1'b1;
        tick();

        // Write 0x10 <= BEEF, WRITE_LATENCY=1
        wr1 = 1'b1; addr1 = 8'h10; wdata1 = 16'hBEEF;
        tick(); wr1 = 1'b0;
        check_eq("wr_busy",       16'(busy1), 16'd1);
        check_eq("wr_done_early", 16'(wd1),   16'd0);
        tick();
        check_eq("wr_done",       16'(wd1),   16'd1);
        check_eq("wr_busy_clr",   16'(busy1), 16'd0);
        check_eq("wr_err",        16'(err1),  16'd0);
        tick();
        check_eq("wr_done_pulse", 16'(wd1),   16'd0);

        // Read 0x10, READ_LATENCY=2
        rd1 = 1'b1;
        tick(); rd1 = 1'b0;
        check_eq("rd_busy",   16'(busy1), 16'd1);
        check_eq("rd_vr_n0",  16'(vr1),   16'd0);
        tick();
        check_eq("rd_vr_n1",  16'(vr1),   16'd0);
        tick();
        check_eq("rd_vr",     16'(vr1),   16'd1);
        check_eq("rd_data",   load1,      16'hBEEF);
        check_eq("rd_busy_clr", 16'(busy1), 16'd0);
        tick();
        check_eq("rd_vr_pulse", 16'(vr1), 16'd0);
        check_eq("rd_hold",   load1,      16'hBEEF);

        // Write 0xFF then read it on the first legal edge (N+2)
        wr1 = 1'b1; addr1 = 8'hFF; wdata1 = 16'h0001;
        tick(); wr1 = 1'b0;
        tick();
        check_eq("raw_wd", 16'(wd1), 16'd1);
        rd1 = 1'b1;
        tick(); rd1 = 1'b0;
        check_eq("raw_busy", 16'(busy1), 16'd1);
        check_eq("raw_wd_clr", 16'(wd1), 16'd0);
        repeat (2) tick();
        check_eq("raw_vr",   16'(vr1),  16'd1);
        check_eq("raw_data", load1,     16'h0001);
        check_eq("raw_err",  16'(err1), 16'd0);
        tick();

        // Simultaneous read+write: write wins, error set
        rd1 = 1'b1; wr1 = 1'b1; addr1 = 8'h20; wdata1 = 16'h1234;
        tick(); rd1 = 1'b0; wr1 = 1'b0;
        check_eq("both_err",  16'(err1),  16'd1);
        check_eq("both_busy", 16'(busy1), 16'd1);
        tick();
        check_eq("both_wd", 16'(wd1), 16'd1);
        check_eq("both_vr", 16'(vr1), 16'd0);
        rd1 = 1'b1;
        tick(); rd1 = 1'b0;
        repeat (2) tick();
        check_eq("both_rd_vr",   16'(vr1), 16'd1);
        check_eq("both_rd_data", load1,    16'h1234);
        repeat (3) tick();
        check_eq("both_err_sticky", 16'(err1), 16'd1);

        // Reset clears the error but not the memory
        rst1 = 1'b0;
        tick();
        check_eq("rst2_err", 16'(err1), 16'd0);
        rst1 = 1'b1;
        tick();

        // Rising readReq during READ_WAIT: ignored, error set
        addr1 = 8'h10; rd1 = 1'b1;
        tick(); rd1 = 1'b0;
        tick();
        check_eq("busyrd_err_pre", 16'(err1), 16'd0);
        rd1 = 1'b1;
        tick(); rd1 = 1'b0;
        check_eq("busyrd_vr",   16'(vr1),  16'd1);
        check_eq("busyrd_data", load1,     16'hBEEF);
        check_eq("busyrd_err",  16'(err1), 16'd1);
        pulses = 0;
        repeat (4) begin
            tick();
            pulses += int'(vr1);
        end
        check_eq("busyrd_extra_vr", 16'(pulses), 16'd0);

        // WRITE_LATENCY=3: seed 0x30 with 5555
        wr3 = 1'b1; addr3 = 8'h30; wdata3 = 16'h5555;
        tick(); wr3 = 1'b0;
        repeat (2) tick();
        check_eq("wl3_wd_early", 16'(wd3), 16'd0);
        tick();
        check_eq("wl3_wd", 16'(wd3), 16'd1);
        tick();

        // Reset one cycle into a write of AAAA: write is lost
        wr3 = 1'b1; wdata3 = 16'hAAAA;
        tick(); wr3 = 1'b0;
        tick();
        rst3 = 1'b0;
        #1;
        check_eq("abort_load", load3,       16'h0000);
        check_eq("abort_vr",   16'(vr3),    16'd0);
        check_eq("abort_wd",   16'(wd3),    16'd0);
        check_eq("abort_busy", 16'(busy3),  16'd0);
        check_eq("abort_err",  16'(err3),   16'd0);
        pulses = 0;
        repeat (3) begin
            tick();
            pulses += int'(wd3);
        end
        check_eq("abort_no_wd", 16'(pulses), 16'd0);
        rst3 = 1'b1;
        tick();
        rd3 = 1'b1;
        tick(); rd3 = 1'b0;
        repeat (2) tick();
        check_eq("abort_rd_vr",   16'(vr3), 16'd1);
        check_eq("abort_rd_data", load3,    16'h5555);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder: the memory end of the execute stage's load/store interface.
- Accepts a load request (`readReq`) or store request (`writeReq`) with an 8-bit address. Returns load data with a one-cycle `valueReady` pulse; acknowledges stores with a one-cycle `writeDone` pulse.
- Response latency is programmable and models a slow memory behind the 3-stage pipeline.

Parameters:
- READ_LATENCY, 2, cycles from request-sampling edge to `valueReady` edge; legal range 1..15.
- WRITE_LATENCY, 1, cycles from request-sampling edge to write commit / `writeDone` edge; legal range 1..15.
- DEPTH, 256, number of 16-bit words; address is 8 bits, and this value is fixed by the address width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- readReq  in  1  load request; sampled only in IDLE.
- writeReq  in  1  store request; sampled only in IDLE.
- memAddr  in  8  word address; captured with the request.
- memValueStore  in  16  store data; captured with the request.
- memValueLoad  out  16  load data; holds its value until the next load completes.
- valueReady  out  1  one-cycle pulse: `memValueLoad` is valid.
- writeDone  out  1  one-cycle pulse: store committed.
- busy  out  1  high while a request is in flight.
- reqError  out  1  sticky flag; set on protocol violation, cleared only by reset.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=IDLE, counter=0, `memValueLoad`=0, `valueReady`=0, `writeDone`=0, `busy`=0, `reqError`=0.
  - Memory array contents are not reset.
- States: IDLE, READ_WAIT, WRITE_WAIT.
- IDLE:
  - `writeReq`=1 at edge N: capture address/data, counter=WRITE_LATENCY-1, `busy`=1.
    - If WRITE_LATENCY=1: commit immediately at edge N+1 (see WRITE_WAIT commit rule).
    - Otherwise go to WRITE_WAIT.
  - `readReq`=1 (and `writeReq`=0) at edge N: capture address, counter=READ_LATENCY-1, `busy`=1, go to READ_WAIT.
  - Both requests high at edge N: the write wins, the read is dropped, and `reqError` is set.
- READ_WAIT:
  - Decrement counter each edge.
  - On the edge where the counter is 0 (edge N+READ_LATENCY):
    - `memValueLoad` <= mem[addr], `valueReady`=1 for exactly one cycle.
    - `busy`=0, go to IDLE.
- WRITE_WAIT:
  - Decrement counter each edge.
  - On the edge where the counter is 0 (edge N+WRITE_LATENCY):
    - mem[addr] <= data, `writeDone`=1 for one cycle.
    - `busy`=0, go to IDLE.
- Back-to-back requests: the earliest next request is sampled at edge N+LAT+1, the edge after the pulse. Steady-state throughput is one request per LAT+1 cycles.
- Request high while `busy`=1: ignored, not queued; `reqError` is set.
  - Exception: a request held continuously from acceptance is not an error. An error is flagged only on a 0->1 transition of `readReq`/`writeReq` while busy (edge detect via registered copies).
- Read after write to the same address: the write commits before IDLE is re-entered, so the read returns the new value.
- `valueReady` and `writeDone` are never high in the same cycle. Each pulses exactly once per accepted request.
- Reset mid-operation:
  - Transaction aborted; no pulse is emitted.
  - A write not yet committed is lost, and the memory keeps its old value.
- Address is a full 8-bit index; no wrap or out-of-range case exists.

Decomposition:
- Shared package: state encoding constants (IDLE=0, READ_WAIT=1, WRITE_WAIT=2), address width 8, data width 16, latency counter width 4.
- One sub-module is natural: `mem_array_256x16` holds the storage, with a synchronous write port and a combinational read port.
- The FSM, counter and handshake logic stay in the top module.

Test Plan:
- Reset release, then `writeReq` addr=8'h10 data=16'hBEEF -> `writeDone` pulses 1 cycle after sampling (WRITE_LATENCY=1), `busy` high 1 cycle, `reqError`=0.
- Read addr=8'h10 -> `valueReady` pulses exactly 2 cycles after sampling; `memValueLoad`=16'hBEEF and holds after the pulse.
- Write addr=8'hFF data=16'h0001, then read 8'hFF on the first legal edge -> returns 16'h0001; the second request is sampled at edge N+2.
- `readReq` and `writeReq` together, addr=8'h20 data=16'h1234 -> write performed, no `valueReady`, `reqError`=1 and stays 1 until reset.
- New `readReq` rising during READ_WAIT -> ignored (only one `valueReady`), `reqError`=1.
- Drop `rst` one cycle into a write to 8'h30 (WRITE_LATENCY=3, old value 16'h5555) -> no `writeDone`; a read after reset returns 16'h5555; all outputs 0 during reset.
